result_buffer: RTL and testbench

- Output stage directly downstream of the compute controller/datapath.
- Captures each finished result on the controller's one-cycle output_valid pulse.
- Holds captured results in a small first-word-fall-through FIFO and drains them to a consumer over a valid/ready handshake.
- Decouples the compute core from a consumer that may stall, so results are not lost while the core returns to WAITING and starts the next computation.

---
 rtl/result_buffer.sv | 93 +++++++++
 tb/tb_result_buffer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/result_buffer.sv
// Result buffer: captures one-cycle result strobes into a small FWFT FIFO and
// drains them to a consumer over valid/ready, flagging any dropped result.
module result_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         results_total
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic              push, pop, drop;

  // Flags come only from registered count, so out_valid never sees in_valid.
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = ~empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign results_total = total_q;

  assign pop  = out_valid & out_ready;
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    total_d    = total_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      total_d  = total_q + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is deliberately not reset; count gates visibility, so stale words never leak out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      total_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      total_q    <= total_d;
    end
  end

endmodule

// File: tb/tb_result_buffer.sv
// Directed bench for result_buffer: fall-through, full/drop, push+pop on full,
// pointer wrap, reset priority and results_total wrap, with hand-computed expectations.
module tb_result_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        overflow;
  logic [7:0]  results_total;

  int n_vec = 0;
  int n_err = 0;

  result_buffer #(.DATA_W(16), .DEPTH(4), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow),
    .results_total (results_total)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] d);
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain_expect(input string tag, input logic [15:0] first, input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_data"}, out_data, first + 16'(i));
      step();
    end
    out_ready = 1'b0;
    check({tag, "_empty"}, empty, 1);
    check({tag, "_ovalid0"}, out_valid, 0);
  endtask

  initial begin
    int max_cnt;

    // Reset state
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_total", results_total, 0);

    // Single push, one-cycle fall-through
    push_word(16'h00A5);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 16'h00A5);
    check("t1_count", count, 1);
    check("t1_empty", empty, 0);
    check("t1_total", results_total, 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("t1_drained", empty, 1);
    // out_ready on empty FIFO changes nothing
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("t1_idle_count", count, 0);
    check("t1_idle_total", results_total, 1);

    // Fill to full, stall, then drain in order
    do_reset();
    for (int i = 1; i <= 4; i++) push_word(16'(i));
    check("t2_full", full, 1);
    check("t2_count", count, 4);
    step();
    check("t2_stall_data", out_data, 16'h0001);
    check("t2_stall_valid", out_valid, 1);
    drain_expect("t2", 16'h0001, 4);

    // Drop on full without pop
    do_reset();
    for (int i = 1; i <= 4; i++) push_word(16'(i));
    push_word(16'h0005);
    check("t3_overflow", overflow, 1);
    check("t3_count", count, 4);
    check("t3_total", results_total, 4);
    drain_expect("t3", 16'h0001, 4);
    push_word(16'h0042);
    step();
    check("t3_sticky", overflow, 1);
    check("t3_after_data", out_data, 16'h0042);

    // Push with simultaneous pop while full
    do_reset();
    for (int i = 1; i <= 4; i++) push_word(16'(i));
    in_valid = 1'b1; in_data = 16'h0005; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("t4_overflow", overflow, 0);
    check("t4_count", count, 4);
    check("t4_full", full, 1);
    check("t4_total", results_total, 5);
    drain_expect("t4", 16'h0002, 4);

    // Push+ready while empty is push only; then wrap with push/pop pairs
    do_reset();
    in_valid = 1'b1; in_data = 16'h00EE; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("t5_empty_push_count", count, 1);
    check("t5_empty_push_data", out_data, 16'h00EE);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    max_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      push_word(16'h0010 + 16'(i));
      if (int'(count) > max_cnt) max_cnt = int'(count);
      check("t5_wrap_data", out_data, 16'h0010 + 16'(i));
      out_ready = 1'b1; step(); out_ready = 1'b0;
      check("t5_wrap_empty", empty, 1);
    end
    check("t5_max_count", max_cnt, 1);
    check("t5_total", results_total, 11);

    // Reset wins over a simultaneous push, clearing a set overflow mid-operation
    do_reset();
    for (int i = 1; i <= 4; i++) push_word(16'(i));
    push_word(16'h0009);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("t6_pre_count", count, 3);
    check("t6_pre_overflow", overflow, 1);
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h0077;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);
    check("t6_valid", out_valid, 0);
    check("t6_overflow", overflow, 0);
    check("t6_total", results_total, 0);

    // 256 accepted pushes under continuous drain: results_total wraps to 0
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 16'h0100 + 16'(i);
      step();
      if (i % 64 == 63) check("t7_head", out_data, 16'h0100 + 16'(i));
      if (i == 254) check("t7_total_255", results_total, 255);
    end
    in_valid = 1'b0;
    check("t7_total_wrap", results_total, 0);
    check("t7_count", count, 1);
    check("t7_overflow", overflow, 0);
    step();
    out_ready = 1'b0;
    check("t7_drained", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
